axis_nibble_unpacker: RTL and testbench

- AXI-stream style nibble de-packer: the transmit-side counterpart to the team's nibble packer.
- Accepts dense 16-bit words, each up to 4 nibbles, and re-emits them as sparse beats carrying a programmable nibble count per beat (1-4).
- Keep uses the team's bit-count encoding: 0, 4, 8, 12, 16.
- Sits between the packed-data source and downstream consumers that take narrow, partially-filled beats.

---
 rtl/axis_nibble_unpacker_pkg.sv | 44 ++++
 rtl/axis_nibble_unpacker_if.sv | 16 +
 rtl/axis_nibble_unpacker_nib_shift_buf.sv | 52 +++++
 rtl/axis_nibble_unpacker.sv | 130 +++++++++++++
 tb/tb_axis_nibble_unpacker.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_nibble_unpacker_pkg.sv
// Shared constants, keep/nibble conversions and FSM state type for the nibble unpacker.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package axis_nib_pkg;

  localparam int NIB_W    = 4;
  localparam int KEEP_W   = 8;
  localparam int DATA_W   = 16;
  localparam int BUF_NIBS = 8;
  localparam int MAX_NIBS = DATA_W / NIB_W;

  // Keep is a count of valid bits, always a multiple of a nibble.
  localparam logic [KEEP_W-1:0] KEEP_0  = 8'd0;
  localparam logic [KEEP_W-1:0] KEEP_4  = 8'd4;
  localparam logic [KEEP_W-1:0] KEEP_8  = 8'd8;
  localparam logic [KEEP_W-1:0] KEEP_12 = 8'd12;
  localparam logic [KEEP_W-1:0] KEEP_16 = 8'd16;

  typedef enum logic {RUN, FLUSH} state_t;

  // Bit count to nibble count; the low two bits are ignored and anything above 16 saturates at 4.
  function automatic logic [2:0] keep_to_nibs(input logic [KEEP_W-1:0] keep);
    logic [KEEP_W-1:0] q;
    q = keep >> 2;
    return (q >= 8'd4) ? 3'd4 : q[2:0];
  endfunction

  // Nibble count (0-4) to bit count.
  function automatic logic [KEEP_W-1:0] nibs_to_keep(input logic [2:0] nibs);
    case (nibs)
      3'd0:    return KEEP_0;
      3'd1:    return KEEP_4;
      3'd2:    return KEEP_8;
      3'd3:    return KEEP_12;
      default: return KEEP_16;
    endcase
  endfunction

  // Out-of-range beat sizes fall back to a full 4-nibble beat.
  function automatic logic [2:0] cfg_decode(input logic [2:0] cfg);
    return (cfg >= 3'd1 && cfg <= 3'd4) ? cfg : 3'd4;
  endfunction

endpackage

// File: rtl/axis_nibble_unpacker_if.sv
// Stream bundle: 16-bit data, bit-count keep, valid/ready/last.
// Latency: n/a (wires only).
// Backpressure: ready flows from slave back to master.
interface axis_nibble_unpacker_if;
  import axis_nib_pkg::*;

  logic [DATA_W-1:0] data;
  logic [KEEP_W-1:0] keep;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, keep, valid, last, input ready);
  modport slave  (input data, keep, valid, last, output ready);

endinterface

// File: rtl/axis_nibble_unpacker_nib_shift_buf.sv
// Eight-nibble FIFO with 0-4 nibble append and 0-4 nibble extract per cycle; head nibble sits at slot 0.
// Latency: appended nibbles are visible on out_dat the cycle after the append.
// Backpressure: none internally; the caller keeps n_out <= count and count - n_out + n_in <= 8.
module nib_shift_buf
  import axis_nib_pkg::*;
(
  input  logic              clk,
  input  logic              arst,
  input  logic [DATA_W-1:0] in_dat,
  input  logic [2:0]        n_in,
  input  logic [2:0]        n_out,
  output logic [DATA_W-1:0] out_dat,
  output logic [3:0]        count
);

  logic [NIB_W-1:0] mem     [BUF_NIBS];
  logic [NIB_W-1:0] mem_nxt [BUF_NIBS];
  logic [3:0]       rem;
  logic [3:0]       src;
  logic [3:0]       off;

  // Shift out the extracted nibbles, then place new nibbles right after the survivors.
  always_comb begin
    rem = count - {1'b0, n_out};
    src = '0;
    off = '0;
    for (int i = 0; i < BUF_NIBS; i++) begin
      src        = 4'(i) + {1'b0, n_out};
      off        = 4'(i) - rem;
      mem_nxt[i] = '0;
      if (src < count) begin
        mem_nxt[i] = mem[src[2:0]];
      end else if (4'(i) >= rem && off < {1'b0, n_in}) begin
        mem_nxt[i] = in_dat[{off[1:0], 2'b00} +: NIB_W];
      end
    end
  end

  // Storage and occupancy update.
  always_ff @(posedge clk) begin
    if (arst) begin
      count <= '0;
      for (int i = 0; i < BUF_NIBS; i++) mem[i] <= '0;
    end else begin
      count <= rem + {1'b0, n_in};
      for (int i = 0; i < BUF_NIBS; i++) mem[i] <= mem_nxt[i];
    end
  end

  assign out_dat = {mem[3], mem[2], mem[1], mem[0]};

endmodule

// File: rtl/axis_nibble_unpacker.sv
// Unpacks dense 16-bit nibble words into beats of a per-packet nibble count (1-4), ending each packet with one last.
// Latency: input handshake at edge k gives m.valid after edge k+1 at the earliest; 1 beat/cycle sustained at N=4.
// Backpressure: full output register holds while m.ready=0; s.ready is registered and drops when the buffer nears full or during flush.
module axis_nibble_unpacker
  import axis_nib_pkg::*;
(
  input  logic                   clk,
  input  logic                   arst,
  input  logic [2:0]             cfg_nibs,
  axis_nibble_unpacker_if.slave  s,
  axis_nibble_unpacker_if.master m
);

  state_t            state_q, state_d;
  logic [2:0]        cfg_q;
  logic              in_pkt_q;
  logic              last_done_q;
  logic              s_ready_q;
  logic              m_valid_q;
  logic              m_last_q;
  logic [KEEP_W-1:0] m_keep_q;
  logic [DATA_W-1:0] m_data_q;

  logic              s_hs;
  logic              out_free;
  logic              ld;
  logic              ld_last;
  logic [2:0]        n_in;
  logic [2:0]        n_out;
  logic [3:0]        cnt;
  logic [3:0]        cnt_d;
  logic [DATA_W-1:0] buf_dat;
  logic [DATA_W-1:0] beat_dat;

  assign s_hs     = s_ready_q && s.valid;
  assign n_in     = s_hs ? keep_to_nibs(s.keep) : 3'd0;
  assign out_free = !m_valid_q || m.ready;

  nib_shift_buf u_buf (
    .clk     (clk),
    .arst    (arst),
    .in_dat  (s.data),
    .n_in    (n_in),
    .n_out   (n_out),
    .out_dat (buf_dat),
    .count   (cnt)
  );

  // Choose the next output beat: a full N-nibble beat, a short flush tail, or an empty last beat.
  always_comb begin
    ld      = 1'b0;
    ld_last = 1'b0;
    n_out   = 3'd0;
    if (out_free) begin
      if (cnt >= {1'b0, cfg_q}) begin
        ld      = 1'b1;
        n_out   = cfg_q;
        // Closes the packet if nothing else can follow: flushing, or a zero-nibble last beat arriving now.
        ld_last = (cnt == {1'b0, cfg_q}) &&
                  ((state_q == FLUSH) || (s_hs && s.last && n_in == 3'd0));
      end else if (state_q == FLUSH && cnt != 4'd0) begin
        ld      = 1'b1;
        n_out   = cnt[2:0];
        ld_last = 1'b1;
      end else if (state_q == FLUSH && !last_done_q) begin
        ld      = 1'b1;
        ld_last = 1'b1;
      end
    end
  end

  // Zero the nibble lanes beyond the beat's count.
  always_comb begin
    beat_dat = '0;
    for (int k = 0; k < MAX_NIBS; k++) begin
      if (3'(k) < n_out) beat_dat[k*NIB_W +: NIB_W] = buf_dat[k*NIB_W +: NIB_W];
    end
  end

  // Next occupancy and packet state, used to register s.ready one cycle ahead.
  always_comb begin
    cnt_d   = cnt - {1'b0, n_out} + {1'b0, n_in};
    state_d = state_q;
    if (state_q == RUN && s_hs && s.last) begin
      state_d = FLUSH;
    end else if (state_q == FLUSH && last_done_q && out_free) begin
      state_d = RUN;
    end
  end

  // Packet FSM, per-packet config latch, registered ready and the output register.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q     <= RUN;
      cfg_q       <= 3'd4;
      in_pkt_q    <= 1'b0;
      last_done_q <= 1'b0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_keep_q    <= '0;
      m_data_q    <= '0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == RUN) && (cnt_d <= 4'd4);
      if (s_hs) in_pkt_q <= !s.last;
      if (s_hs && !in_pkt_q) cfg_q <= cfg_decode(cfg_nibs);
      if (state_q == FLUSH && state_d == RUN) begin
        last_done_q <= 1'b0;
      end else if (ld && ld_last) begin
        last_done_q <= 1'b1;
      end
      if (ld) begin
        m_valid_q <= 1'b1;
        m_data_q  <= beat_dat;
        m_keep_q  <= nibs_to_keep(n_out);
        m_last_q  <= ld_last;
      end else if (m.ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign s.ready = s_ready_q;
  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;
  assign m.keep  = m_keep_q;
  assign m.last  = m_last_q;

endmodule

// File: tb/tb_axis_nibble_unpacker.sv
// Randomised and directed bench for axis_nibble_unpacker with a queue-based reference model and scoreboard.
// Latency: n/a.
// Backpressure: output ready driven in several patterns by the monitor process.
module tb_axis_nibble_unpacker;
  import axis_nib_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic       clk = 1'b0;
  logic       arst;
  logic [2:0] cfg_nibs;

  axis_nibble_unpacker_if s_if ();
  axis_nibble_unpacker_if m_if ();

  axis_nibble_unpacker dut (
    .clk      (clk),
    .arst     (arst),
    .cfg_nibs (cfg_nibs),
    .s        (s_if),
    .m        (m_if)
  );

  always #5 clk = ~clk;

  int    n_checks    = 0;
  int    n_pass      = 0;
  int    cyc         = 0;
  int    rdy_mode    = 0;
  bit    mon_en      = 1'b0;
  int    stall_total = 0;
  int    n_beats     = 0;
  int    pop_cyc[$];
  beat_t exp_q[$];

  // reference model state: pending nibbles of the open packet
  logic [3:0] pend[$];
  int         pkt_n    = 4;
  bit         in_pkt_m = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: got timeout, required completion", name);
  endtask

  task automatic emit(input int take, input bit last);
    beat_t b;
    b.d = '0;
    for (int j = 0; j < take; j++) b.d[j*4 +: 4] = pend.pop_front();
    b.k = 8'(take * 4);
    b.l = last;
    exp_q.push_back(b);
  endtask

  // A packet's nibbles cut into N-sized beats; the final (possibly short) beat carries last.
  // An empty packet yields one zero beat. Non-final input beats can only release full beats.
  task automatic model_beat(input logic [15:0] d, input logic [7:0] k, input logic l, input logic [2:0] cfg);
    int n;
    if (!in_pkt_m) begin
      pkt_n    = (cfg >= 3'd1 && cfg <= 3'd4) ? int'(cfg) : 4;
      in_pkt_m = 1'b1;
    end
    n = int'(k) / 4;
    if (n > 4) n = 4;
    for (int j = 0; j < n; j++) pend.push_back(d[j*4 +: 4]);
    if (!l) begin
      while (pend.size() >= pkt_n) emit(pkt_n, 1'b0);
    end else begin
      if (pend.size() == 0) emit(0, 1'b1);
      else begin
        while (pend.size() > 0) begin
          int take;
          take = (pend.size() < pkt_n) ? pend.size() : pkt_n;
          emit(take, pend.size() == take);
        end
      end
      in_pkt_m = 1'b0;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic [7:0] k, input logic l, input logic [2:0] cfg);
    int w = 0;
    @(negedge clk);
    s_if.valid = 1'b1;
    s_if.data  = d;
    s_if.keep  = k;
    s_if.last  = l;
    cfg_nibs   = cfg;
    while (!s_if.ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    stall_total += w;
    if (!s_if.ready) begin
      fail("send_handshake");
      s_if.valid = 1'b0;
    end else begin
      model_beat(d, k, l, cfg);
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    s_if.valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int w = 0;
    idle(0);
    while ((exp_q.size() != 0 || m_if.valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 3000) fail("drain");
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_ready"}, s_if.ready, 0);
    chk({tag, "_m_valid"}, m_if.valid, 0);
    chk({tag, "_m_last"},  m_if.last,  0);
    chk({tag, "_m_keep"},  m_if.keep,  0);
    chk({tag, "_m_data"},  m_if.data,  0);
  endtask

  // Monitor: drives m.ready, checks held beats stay stable, and scores every accepted beat.
  initial begin
    beat_t       e;
    bit          held;
    bit          r;
    logic [15:0] hd;
    logic [7:0]  hk;
    logic        hl;
    held        = 1'b0;
    m_if.ready  = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        2:       r = (cyc % 3 == 0);
        default: r = 1'b0;
      endcase
      m_if.ready = r;
      if (!mon_en) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", m_if.valid, 1);
          chk("hold_data",  m_if.data,  hd);
          chk("hold_keep",  m_if.keep,  hk);
          chk("hold_last",  m_if.last,  hl);
          held = 1'b0;
        end
        if (m_if.valid && r) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: got data 0x%0h keep %0d last %0d, required no beat",
                     m_if.data, m_if.keep, m_if.last);
          end else begin
            e = exp_q.pop_front();
            chk("m_data", m_if.data, e.d);
            chk("m_keep", m_if.keep, e.k);
            chk("m_last", m_if.last, e.l);
            pop_cyc.push_back(cyc);
            n_beats++;
          end
        end else if (m_if.valid) begin
          held = 1'b1;
          hd   = m_if.data;
          hk   = m_if.keep;
          hl   = m_if.last;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, required finish");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb0;
    arst       = 1'b1;
    s_if.valid = 1'b0;
    s_if.data  = '0;
    s_if.keep  = '0;
    s_if.last  = 1'b0;
    cfg_nibs   = 3'd4;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    arst     = 1'b0;
    mon_en   = 1'b1;
    rdy_mode = 0;

    // one nibble per beat across two words
    send(16'h4321, KEEP_16, 1'b0, 3'd1);
    send(16'h8765, KEEP_16, 1'b1, 3'd1);
    drain();

    // three-nibble beats with a short tail
    send(16'hDCBA, KEEP_16, 1'b1, 3'd3);
    drain();

    // full-rate pass-through
    stall_total = 0;
    pop_cyc.delete();
    send(16'h1111, KEEP_16, 1'b0, 3'd4);
    send(16'h2222, KEEP_16, 1'b0, 3'd4);
    send(16'h3333, KEEP_16, 1'b1, 3'd4);
    drain();
    chk("full_rate_input_stalls", stall_total, 0);
    chk("full_rate_beat_spacing", (pop_cyc.size() == 3) ? (pop_cyc[2] - pop_cyc[0]) : -1, 2);

    // backpressure 1,0,0 with two-nibble beats
    rdy_mode    = 2;
    stall_total = 0;
    send(16'h3210, KEEP_16, 1'b0, 3'd2);
    send(16'h7654, KEEP_16, 1'b0, 3'd2);
    send(16'hBA98, KEEP_16, 1'b0, 3'd2);
    send(16'hFEDC, KEEP_16, 1'b1, 3'd2);
    drain();
    chk("backpressure_s_ready_dropped", stall_total > 0, 1);
    rdy_mode = 0;

    // empty packet -> single zero beat
    send(16'hFFFF, KEEP_0, 1'b1, 3'd2);
    drain();

    // out-of-range configs behave as 4
    send(16'h9876, KEEP_16, 1'b0, 3'd0);
    send(16'h5432, KEEP_8,  1'b1, 3'd0);
    drain();
    send(16'hCAFE, KEEP_12, 1'b1, 3'd7);
    drain();

    // randomised packets; cfg changes after the first beat must be ignored
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      bit       empty;
      int       nb;
      logic [2:0] cfg0;
      cfg0  = 3'($urandom_range(0, 7));
      empty = ($urandom_range(0, 9) == 0);
      nb    = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        bit         last;
        logic [7:0] k;
        last = (b == nb - 1);
        if (empty) k = 8'($urandom_range(0, 3));
        else if (last) begin
          if ($urandom_range(0, 3) == 0) k = 8'($urandom_range(4, 255));
          else k = nibs_to_keep(3'($urandom_range(1, 4))) | 8'($urandom_range(0, 3));
        end else begin
          case ($urandom_range(0, 3))
            0:       k = 8'($urandom_range(0, 255));
            1:       k = 8'($urandom_range(0, 3));
            default: k = nibs_to_keep(3'($urandom_range(1, 4)));
          endcase
        end
        send(16'($urandom()), k, last, (b == 0) ? cfg0 : 3'($urandom_range(0, 7)));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
      end
    end
    drain();

    // reset while a beat is stalled at the output
    rdy_mode = 3;
    send(16'h5555, KEEP_16, 1'b0, 3'd4);
    idle(0);
    repeat (2) @(negedge clk);
    chk("pre_reset_m_valid", m_if.valid, 1);
    mon_en = 1'b0;
    arst   = 1'b1;
    @(negedge clk);
    chk_outputs_zero("midreset");
    exp_q.delete();
    pend.delete();
    in_pkt_m = 1'b0;
    arst     = 1'b0;
    rdy_mode = 0;
    @(negedge clk);
    mon_en = 1'b1;
    nb0    = n_beats;
    send(16'hABCD, KEEP_16, 1'b1, 3'd4);
    drain();
    chk("post_reset_beat_count", n_beats - nb0, 1);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
